// File: rtl/rn_coeff_buffer_if.sv
// rn_coeff_buffer_if: write-side and read-side handshake bundle for rn_coeff_buffer.
//   in_valid / in_data / in_ready      : producer writes one coefficient per accepted beat
//   out_valid / out_data / out_last /
//   out_ready                          : consumer reads one coefficient per accepted beat
// Modports:
//   master : the environment (drives in_*, out_ready)
//   slave  : the buffer      (drives in_ready, out_*)
interface rn_coeff_buffer_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rn_coeff_buffer.sv
// rn_coeff_buffer: frame buffer for DEPTH autocorrelation coefficients.
// A frame is started with start (IDLE only), filled with DEPTH words over the write
// handshake, then read back in order over the read handshake, one word per two cycles
// (request cycle + hold cycle). A one-cycle done pulse closes the frame.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : frame start request, honoured in IDLE only
//   bus      : rn_coeff_buffer_if.slave (in_valid/in_data/in_ready, out_valid/out_data/
//              out_last/out_ready)
//   busy     : high in every state except IDLE
//   done     : single-cycle frame-complete pulse
//   chk_err  : sticky write/read checksum mismatch flag
//
// Optional feature: define RN_CHECKSUM_EN to accumulate modulo-2^DATA_W sums of written
// and read words and flag a mismatch in DONE. Without it chk_err is tied low.
//
// Memory contents are deliberately not reset; every frame rewrites all DEPTH words
// before any of them are read.
module rn_coeff_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  rn_coeff_buffer_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic               chk_err
);

  // Memory index width; DEPTH <= 2^ADDR_W so this never exceeds ADDR_W.
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdReq,
    StRdHold,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_q;
  logic [IdxW-1:0]     idx;

  logic                wr_en;
  logic                rd_en;
  logic                start_acc;  // start accepted this cycle
  logic                rd_acc;     // read word accepted this cycle
  logic                in_ready;
  logic                out_valid;
  logic                out_last;

  assign idx = addr_q[IdxW-1:0];

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    rd_acc    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          addr_d    = '0;
          state_d   = StWrite;
        end
      end

      StWrite: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StRdReq;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      StRdReq: begin
        rd_en   = 1'b1;
        state_d = StRdHold;
      end

      StRdHold: begin
        out_valid = 1'b1;
        out_last  = (addr_q == LastAddr);
        if (bus.out_ready) begin
          rd_acc = 1'b1;
          if (addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StRdReq;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        addr_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and address registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset on the array itself, only on the registered read port so
  // out_data reads zero straight out of reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= bus.in_data;
    end
  end

  // Read data only changes in RD_REQ, so it holds steady through any RD_HOLD stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[idx];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = rd_q;
  assign bus.out_last  = out_last;

  // ---------------------------------------------------------------------------
  // Optional checksum
  // ---------------------------------------------------------------------------
`ifdef RN_CHECKSUM_EN
  logic [DATA_W-1:0] wr_sum_q;
  logic [DATA_W-1:0] rd_sum_q;
  logic              chk_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      chk_err_q <= 1'b0;
    end else if (start_acc) begin
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_sum_q <= wr_sum_q + bus.in_data;
      end
      if (rd_acc) begin
        rd_sum_q <= rd_sum_q + rd_q;
      end
      // Last read is accepted before DONE, so both sums are final here.
      if ((state_q == StDone) && (wr_sum_q != rd_sum_q)) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{start_acc, rd_acc};
  assign chk_err    = 1'b0;
`endif

endmodule

// File: doc/rn_coeff_buffer.md
RN_COEFF_BUFFER -- requirements
Module: rn_coeff_buffer

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, word width of each autocorrelation coefficient.
REQ-002 SHALL provide parameter ADDR_W, default 9, buffer address width.
REQ-003 SHALL provide parameter DEPTH, default 11, number of words per frame; legal range 1 to 2^ADDR_W.
REQ-004 SHALL provide port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port start, input, 1, frame start request, sampled in IDLE only.
REQ-007 SHALL provide port in_valid, input, 1, write-side data valid.
REQ-008 SHALL provide port in_data, input, DATA_W, write-side coefficient.
REQ-009 SHALL provide port in_ready, output, 1, write-side accept.
REQ-010 SHALL provide port out_valid, output, 1, read-side data valid.
REQ-011 SHALL provide port out_data, output, DATA_W, read-side coefficient.
REQ-012 SHALL provide port out_last, output, 1, high with out_valid on word DEPTH-1.
REQ-013 SHALL provide port out_ready, input, 1, read-side accept.
REQ-014 SHALL provide port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL provide port done, output, 1, single-cycle frame-complete pulse.
REQ-016 SHALL provide port chk_err, output, 1, sticky checksum mismatch flag.

Function
REQ-017 SHALL hold an internal DEPTH x DATA_W synchronous memory; write takes effect at the clock edge; read data is registered with one cycle latency.
REQ-018 SHALL implement states IDLE, WRITE, RD_REQ, RD_HOLD, DONE.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 moves to WRITE with address=0; in_valid is ignored.
REQ-020 WRITE: in_ready=1; each cycle with in_valid=1 writes in_data to the current address and increments the address; the write at address DEPTH-1 moves to RD_REQ with address=0.
REQ-021 RD_REQ: out_valid=0; issues a read of the current address and moves to RD_HOLD unconditionally.
REQ-022 RD_HOLD: out_valid=1, out_data = memory word; out_data and out_last SHALL stay stable while out_ready=0, for any number of cycles.
REQ-023 RD_HOLD with out_ready=1: if out_last, move to DONE, else increment the address and move to RD_REQ; peak read throughput is one word per two cycles.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; frame latency with no stalls is DEPTH write cycles + 2*DEPTH read cycles + 1.
REQ-025 start SHALL be ignored in every state other than IDLE.
REQ-026 DEPTH=1 SHALL work: one write, one read with out_last=1 on it.
REQ-027 Address arithmetic SHALL use ADDR_W bits and never exceed DEPTH-1.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, address=0, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0 and chk_err=0, including mid-frame.
REQ-029 Memory contents SHALL NOT be cleared by reset; a frame started after reset SHALL fully rewrite them before reading.

Configuration
REQ-030 With macro RN_CHECKSUM_EN defined, the block SHALL accumulate the modulo-2^DATA_W sum of written words and of read words, compare them in DONE, and set chk_err on mismatch; chk_err clears on accepted start or reset.
REQ-031 Without RN_CHECKSUM_EN, the block SHALL tie chk_err to 0 and instantiate no accumulators.

Verification
REQ-032 Defaults, start pulse, write 0..10 with in_valid held high, out_ready held high -> out_data 0..10 in order, out_last only on 10, done pulse at cycle 11+22+1 after WRITE entry.
REQ-033 Write 0x0000000F to all 11 words, out_ready low 5 cycles on word 3 -> out_data=0x0000000F held stable, no words skipped or repeated.
REQ-034 rst asserted during RD_HOLD of word 5 -> all outputs zero next edge; a new start followed by a full frame of 0xA0..0xAA reads back 0xA0..0xAA.
REQ-035 DEPTH=1, write 0xDEADBEEF -> a single read with out_last=1, then done.
REQ-036 start pulsed during WRITE and RD_HOLD -> no state or address change.
REQ-037 RN_CHECKSUM_EN defined, memory word forced to differ on readback -> chk_err=1 after DONE and held until next start; matched frame -> chk_err=0.
